// File: rtl/easyaxi_rd_arb.sv
// Read-channel arbiter sharing one single-outstanding AXI read slave.
// EASYAXI_RD_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 16
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif

module easyaxi_rd_arb #(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = $clog2(NUM_MST)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_MST-1:0]                 axi_mst_arvalid,
  output logic [NUM_MST-1:0]                 axi_mst_arready,
  input  logic [NUM_MST*`AXI_ID_W-1:0]       axi_mst_arid,
  input  logic [NUM_MST*`AXI_ADDR_W-1:0]     axi_mst_araddr,
  input  logic [NUM_MST*`AXI_LEN_W-1:0]      axi_mst_arlen,
  input  logic [NUM_MST*`AXI_SIZE_W-1:0]     axi_mst_arsize,
  input  logic [NUM_MST*`AXI_BURST_W-1:0]    axi_mst_arburst,
  output logic [NUM_MST-1:0]                 axi_mst_rvalid,
  input  logic [NUM_MST-1:0]                 axi_mst_rready,
  output logic                               axi_slv_arvalid,
  input  logic                               axi_slv_arready,
  output logic [`AXI_ID_W-1:0]               axi_slv_arid,
  output logic [`AXI_ADDR_W-1:0]             axi_slv_araddr,
  output logic [`AXI_LEN_W-1:0]              axi_slv_arlen,
  output logic [`AXI_SIZE_W-1:0]             axi_slv_arsize,
  output logic [`AXI_BURST_W-1:0]            axi_slv_arburst,
  input  logic                               axi_slv_rvalid,
  output logic                               axi_slv_rready,
  input  logic                               axi_slv_rlast,
  output logic                               arb_busy,
  output logic [IDX_W-1:0]                   arb_owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] win;
  logic             grant;

`ifdef EASYAXI_RD_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is written last.
  always_comb begin
    win = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (axi_mst_arvalid[i]) win = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] last_grant;

  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_MST; k++) begin
      idx = (int'(last_grant) + k) % NUM_MST;
      if (!found && axi_mst_arvalid[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_MST - 1);
    end else if (grant) begin
      last_grant <= win;
    end
  end
`endif

  assign grant = (state_q == IDLE) && (|axi_mst_arvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    axi_mst_arready = '0;
    axi_mst_rvalid  = '0;
    axi_slv_arvalid = 1'b0;
    axi_slv_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          axi_mst_arready[win] = 1'b1;
          state_d              = ADDR;
        end
      end
      ADDR: begin
        axi_slv_arvalid = 1'b1;
        if (axi_slv_arready) state_d = DATA;
      end
      DATA: begin
        axi_mst_rvalid[arb_owner] = axi_slv_rvalid;
        axi_slv_rready = axi_mst_rready[arb_owner];
        if (axi_slv_rvalid && axi_slv_rready && axi_slv_rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_busy = (state_q != IDLE);

  // AR payload is replayed from these registers while in ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_owner       <= '0;
      axi_slv_arid    <= '0;
      axi_slv_araddr  <= '0;
      axi_slv_arlen   <= '0;
      axi_slv_arsize  <= '0;
      axi_slv_arburst <= '0;
    end else if (grant) begin
      arb_owner       <= win;
      axi_slv_arid    <= axi_mst_arid[win*`AXI_ID_W +: `AXI_ID_W];
      axi_slv_araddr  <= axi_mst_araddr[win*`AXI_ADDR_W +: `AXI_ADDR_W];
      axi_slv_arlen   <= axi_mst_arlen[win*`AXI_LEN_W +: `AXI_LEN_W];
      axi_slv_arsize  <= axi_mst_arsize[win*`AXI_SIZE_W +: `AXI_SIZE_W];
      axi_slv_arburst <= axi_mst_arburst[win*`AXI_BURST_W +: `AXI_BURST_W];
    end
  end

endmodule

// File: doc/easyaxi_rd_arb.md
# easyaxi_rd_arb

Read-channel arbiter that shares one single-outstanding AXI read slave (the EASYAXI_SLV read port) between NUM_MST requesting masters. It accepts one AR request at a time from the winning master and replays it to the slave from registers. It then routes R-channel valid/ready between the slave and the owning master until the slave's last beat. R payload (rdata, rresp, rlast) is wired directly from the slave to all masters. Only rvalid and rready are routed.

## Interface
Parameters:
- NUM_MST, 2: number of masters, legal range 2..8.
- IDX_W, $clog2(NUM_MST): owner index width.

Ports (master-side buses are concatenated, with master i in slice i):
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous and active-low
- axi_mst_arvalid  input  NUM_MST  per-master AR valid
- axi_mst_arready  output  NUM_MST  per-master AR ready; one-hot or zero
- axi_mst_arid  input  NUM_MST*`AXI_ID_W  per-master ARID
- axi_mst_araddr  input  NUM_MST*`AXI_ADDR_W  per-master ARADDR
- axi_mst_arlen  input  NUM_MST*`AXI_LEN_W  per-master ARLEN
- axi_mst_arsize  input  NUM_MST*`AXI_SIZE_W  per-master ARSIZE
- axi_mst_arburst  input  NUM_MST*`AXI_BURST_W  per-master ARBURST
- axi_mst_rvalid  output  NUM_MST  routed R valid
- axi_mst_rready  input  NUM_MST  per-master R ready
- axi_slv_arvalid  output  1  AR valid to slave
- axi_slv_arready  input  1  AR ready from slave
- axi_slv_arid / araddr / arlen / arsize / arburst  output  `AXI_*_W each  registered AR payload
- axi_slv_rvalid  input  1  R valid from slave
- axi_slv_rready  output  1  R ready to slave
- axi_slv_rlast  input  1  last beat from slave
- arb_busy  output  1  high whenever the state is not IDLE
- arb_owner  output  IDX_W  index of the current/last granted master

## Operation
State machine, encoded with 2 bits:
- **IDLE**
  - When any axi_mst_arvalid is high, select a winner w.
  - Drive axi_mst_arready[w]=1 combinationally. This completes the master AR handshake in this cycle.
  - Latch w's AR payload into the slave AR registers and set arb_owner=w.
  - Go to ADDR.
  - With no requests, stay in IDLE and keep all readies low.
- **ADDR**
  - axi_slv_arvalid=1 with the payload held stable.
  - On axi_slv_arvalid && axi_slv_arready, go to DATA.
  - An address the slave rejects leaves the block in ADDR indefinitely. This is the required behaviour; there is no timeout.
- **DATA**
  - axi_mst_rvalid[owner]=axi_slv_rvalid; all other rvalid bits are 0.
  - axi_slv_rready=axi_mst_rready[owner].
  - On axi_slv_rvalid && axi_slv_rready && axi_slv_rlast, go to IDLE.
  - Non-last beats stay in DATA.

Arbitration:
- Round-robin.
- Search order starts at (last_grant+1) mod NUM_MST.
- last_grant updates only on a grant.

Outputs and gating:
- axi_slv_rready is 0 outside DATA.
- axi_mst_rvalid is all zeros outside DATA.
- axi_mst_arready is all zeros outside IDLE.
- Requests arriving during ADDR/DATA are held off; the master keeps arvalid asserted per AXI.

Reset:
- State=IDLE; last_grant=NUM_MST-1, so master 0 has priority after reset.
- arb_owner=0.
- Slave AR payload registers = 0.
- All valid/ready outputs = 0, arb_busy=0.
- Asserting reset mid-transaction abandons it immediately. No drain occurs.

## Timing
- Master AR handshake to axi_slv_arvalid high: 1 cycle.
- Slave AR handshake to DATA (R routing active): next cycle.
- R routing is combinational, with zero added latency per beat.
- Last R handshake in cycle N: IDLE in N+1. A pending request can be granted in N+1, and its axi_slv_arvalid rises in N+2.
- Simultaneous requests resolve in a single cycle. Exactly one master is granted.
- A master dropping arvalid before grant (an AXI violation) is simply not granted.
- Payload registers load only on a grant.

## Configuration
- **EASYAXI_RD_ARB_FIXED_PRIO_EN defined:** fixed priority. The lowest-index requesting master always wins, and last_grant is unused.
- **Not defined (default):** round-robin as described under Operation.

## Test plan
- Reset with all inputs 0: all outputs 0, arb_busy=0, arb_owner=0.
- Master 0 alone, araddr=0, arlen=3: one arready pulse. axi_slv_arvalid rises the next cycle with arid/arlen copied. 4 R beats reach master 0 only. IDLE follows the cycle after rlast.
- Masters 0 and 1 request together, arlen=0 each, repeated 4 times: grants alternate 0,1,0,1. With EASYAXI_RD_ARB_FIXED_PRIO_EN: 0,0,0,0 while master 0 keeps requesting.
- axi_mst_rready[owner] toggled low mid-burst: axi_slv_rready follows it. Beats stall and no beat is lost or duplicated. The non-owner rready has no effect.
- Rejected address (araddr=16'h0004): the block stays in ADDR with axi_slv_arvalid=1. A second master remains unserved.
- rst_n asserted during DATA: next edge IDLE, all outputs 0. A new request is granted normally afterwards.
